// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Supports up to MAX_COUNT requesters.
package arb_pkg;

  localparam int MAX_COUNT = 32;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic int onehot_to_idx(input logic [MAX_COUNT-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_COUNT; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Requester-side and output-side stream signals of the arbiter.
// The slave modport is the arbiter itself.
interface rr_stream_arbiter_if #(
  parameter int Count = 2,
  parameter int Width = 8
);
  logic [Count-1:0] req_valid;
  logic [Count-1:0] req_last;
  logic [Width-1:0] req_data [0:Count-1];
  logic [Count-1:0] req_ready;
  logic             out_valid;
  logic             out_last;
  logic [Width-1:0] out_data;
  logic [Count-1:0] out_grant;
  logic             out_ready;

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_last, out_data, out_grant
  );

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_last, out_data, out_grant
  );
endinterface

// File: rtl/rr_stream_arbiter_mux.sv
// AND-OR payload select driven by a one-hot grant.
module onehot_mux #(
  parameter int Count = 2,
  parameter int Width = 8
) (
  input  logic [Count-1:0] sel,
  input  logic [Width-1:0] din [0:Count-1],
  output logic [Width-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < Count; i++) begin
      if (sel[i]) dout = dout | din[i];
    end
  end

endmodule

// File: rtl/rr_stream_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_priority_picker
  import arb_pkg::*;
#(
  parameter  int Count = 2,
  localparam int IdxW  = (Count > 1) ? $clog2(Count) : 1
) (
  input  logic [Count-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [Count-1:0] win_oh,
  output logic [IdxW-1:0]  win_idx
);

  // Scan from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    int j;
    win_oh = '0;
    j      = 0;
    for (int k = Count - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= Count) j = j - Count;
      if (req[j[IdxW-1:0]]) begin
        win_oh               = '0;
        win_oh[j[IdxW-1:0]]  = 1'b1;
      end
    end
  end

  assign win_idx = IdxW'(onehot_to_idx(MAX_COUNT'(win_oh)));

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin stream arbiter with packet lock and a single registered output stage.
// Full throughput: the output register reloads in the same cycle it drains.
module rr_stream_arbiter
  import arb_pkg::*;
#(
  parameter int Count = 2,
  parameter int Width = 8
) (
  input logic                 clk,
  input logic                 reset,
  rr_stream_arbiter_if.slave  bus
);

  localparam int IdxW = (Count > 1) ? $clog2(Count) : 1;

  logic              load;
  logic              accept;
  logic              win_last;
  logic [Count-1:0]  pick_oh;
  logic [Count-1:0]  own_oh;
  logic [Count-1:0]  grant;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   owner_q;
  logic [Width-1:0]  mux_data;
  lock_state_t       state_q;
  lock_state_t       state_nxt;

  logic              vld_p1;
  logic              last_p1;
  logic [Width-1:0]  data_p1;
  logic [Count-1:0]  grant_p1;

  rr_priority_picker #(.Count(Count)) u_picker (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  onehot_mux #(.Count(Count), .Width(Width)) u_mux (
    .sel  (grant),
    .din  (bus.req_data),
    .dout (mux_data)
  );

  assign load = ~vld_p1 | bus.out_ready;

  always_comb begin
    own_oh          = '0;
    own_oh[owner_q] = 1'b1;
  end

  // A locked owner that drops valid produces a bubble rather than yielding.
  always_comb begin
    grant   = pick_oh;
    win_idx = pick_idx;
    if (state_q == LOCKED) begin
      grant   = bus.req_valid[owner_q] ? own_oh : '0;
      win_idx = owner_q;
    end
  end

  assign accept        = load & (|grant) & ~reset;
  assign win_last      = bus.req_last[win_idx];
  assign bus.req_ready = (load & ~reset) ? grant : '0;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      UNLOCKED: if (accept && !win_last) state_nxt = LOCKED;
      LOCKED:   if (accept &&  win_last) state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == UNLOCKED && accept && !win_last) owner_q <= win_idx;
      // Rotation happens only at packet end, so a locked packet keeps its priority slot.
      if (accept && win_last) begin
        if (win_idx == IdxW'(Count - 1)) ptr_q <= '0;
        else                             ptr_q <= win_idx + 1'b1;
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      data_p1  <= '0;
      grant_p1 <= '0;
    end else if (load) begin
      vld_p1 <= accept;
      if (accept) begin
        last_p1  <= win_last;
        data_p1  <= mux_data;
        grant_p1 <= grant;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_grant = grant_p1;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Scoreboard bench for rr_stream_arbiter: a 4-requester instance and a 1-requester instance.
module tb_rr_stream_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [3:0] grant;
    int         vis;
  } beat_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  beat_t q4[$];
  beat_t q1[$];

  int m_ptr;
  int m_owner;
  bit m_locked;

  logic       c1_v;
  logic       c1_l;
  logic       c1_r;
  logic [7:0] c1_d;

  rr_stream_arbiter_if #(.Count(4), .Width(8)) bus4 ();
  rr_stream_arbiter_if #(.Count(1), .Width(8)) bus1 ();

  rr_stream_arbiter #(.Count(4), .Width(8)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  rr_stream_arbiter #(.Count(1), .Width(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One bench cycle: drive inputs, then predict the arbiter decision from the rules.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic r, input logic rst_in);
    int    win;
    bit    load;
    logic [3:0] exp_ready;
    beat_t b;
    @(posedge clk);
    #1;
    reset          = rst_in;
    bus4.req_valid = v;
    bus4.req_last  = l;
    bus4.out_ready = r;
    for (int i = 0; i < 4; i++) bus4.req_data[i] = 8'($urandom);
    bus1.req_valid = c1_v;
    bus1.req_last  = c1_l;
    bus1.req_data[0] = c1_d;
    bus1.out_ready = c1_r;
    #2;
    if (rst_in) begin
      chk("ready_in_reset", 32'(bus4.req_ready), 32'd0);
      chk("ready1_in_reset", 32'(bus1.req_ready), 32'd0);
      q4.delete();
      q1.delete();
      m_ptr    = 0;
      m_owner  = 0;
      m_locked = 0;
    end else begin
      load = (q4.size() == 0) || r;
      win  = -1;
      if (m_locked) begin
        if (v[m_owner]) win = m_owner;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (win < 0 && v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        end
      end
      exp_ready = (load && win >= 0) ? 4'(1 << win) : 4'd0;
      chk("req_ready", 32'(bus4.req_ready), 32'(exp_ready));
      if (load && win >= 0) begin
        b.data  = bus4.req_data[win];
        b.last  = l[win];
        b.grant = 4'(1 << win);
        b.vis   = cyc + 1;
        q4.push_back(b);
        if (l[win]) begin
          m_locked = 0;
          m_ptr    = (win + 1) % 4;
        end else begin
          m_locked = 1;
          m_owner  = win;
        end
      end
      load = (q1.size() == 0) || c1_r;
      chk("req_ready1", 32'(bus1.req_ready), 32'(load && c1_v));
      if (load && c1_v) begin
        b.data  = c1_d;
        b.last  = c1_l;
        b.grant = 4'd1;
        b.vis   = cyc + 1;
        q1.push_back(b);
      end
    end
  endtask

  // Monitor: compares whatever the outputs present against the head of each queue.
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        exp_v = (q4.size() > 0) && (q4[0].vis <= cyc);
        chk("out_valid", 32'(bus4.out_valid), 32'(exp_v));
        if (exp_v && bus4.out_valid) begin
          chk("out_data", 32'(bus4.out_data), 32'(q4[0].data));
          chk("out_last", 32'(bus4.out_last), 32'(q4[0].last));
          chk("out_grant", 32'(bus4.out_grant), 32'(q4[0].grant));
          if (bus4.out_ready) void'(q4.pop_front());
        end
        exp_v = (q1.size() > 0) && (q1[0].vis <= cyc);
        chk("out_valid1", 32'(bus1.out_valid), 32'(exp_v));
        if (exp_v && bus1.out_valid) begin
          chk("out_data1", 32'(bus1.out_data), 32'(q1[0].data));
          chk("out_last1", 32'(bus1.out_last), 32'(q1[0].last));
          chk("out_grant1", 32'(bus1.out_grant), 32'(q1[0].grant));
          if (bus1.out_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    int  tries;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    c1_v = 1'b0; c1_l = 1'b1; c1_r = 1'b1; c1_d = 8'hA5;
    bus4.req_valid = '0; bus4.req_last = '0; bus4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus4.req_data[i] = '0;
    bus1.req_valid = '0; bus1.req_last = '0; bus1.out_ready = 1'b0;
    bus1.req_data[0] = '0;

    repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b1);

    // Reset values are visible in the first idle cycle after reset.
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("rst_out_data", 32'(bus4.out_data), 32'd0);
    chk("rst_out_grant", 32'(bus4.out_grant), 32'd0);
    chk("rst_out_last", 32'(bus4.out_last), 32'd0);

    // All valid, single-beat packets: grant rotates 0,1,2,3,0; Count=1 streams 0xA5.
    c1_v = 1'b1; c1_l = 1'b1; c1_r = 1'b1; c1_d = 8'hA5;
    repeat (5) step(4'b1111, 4'b1111, 1'b1, 1'b0);

    // Three-beat packet on req1 with req0 and req2 competing.
    step(4'b0111, 4'b0101, 1'b1, 1'b0);
    step(4'b0111, 4'b0101, 1'b1, 1'b0);
    step(4'b0111, 4'b0111, 1'b1, 1'b0);
    step(4'b0101, 4'b0101, 1'b1, 1'b0);
    step(4'b0101, 4'b0101, 1'b1, 1'b0);

    // Locked req1 drops valid for two cycles while req3 waits.
    step(4'b1010, 4'b1000, 1'b1, 1'b0);
    step(4'b1000, 4'b1000, 1'b1, 1'b0);
    step(4'b1000, 4'b1000, 1'b1, 1'b0);
    step(4'b1010, 4'b1010, 1'b1, 1'b0);
    step(4'b1000, 4'b1000, 1'b1, 1'b0);

    // Backpressure for five cycles, then drain and load together.
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    repeat (5) step(4'b1111, 4'b1111, 1'b0, 1'b0);
    repeat (3) step(4'b1111, 4'b1111, 1'b1, 1'b0);

    // Reset in the middle of a req2 packet, then all-valid restarts at req0.
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 1'b1);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      c1_v = 1'($urandom);
      c1_l = ($urandom_range(0, 2) == 0);
      c1_r = ($urandom_range(0, 3) != 0);
      c1_d = 8'($urandom);
      step(4'($urandom), 4'($urandom & $urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end

    // Random reset while a packet is locked and a beat is in flight (bounded search).
    tries = 0;
    while (!(m_locked && q4.size() > 0) && tries < 300) begin
      step(4'($urandom), 4'd0, 1'b1, 1'b0);
      tries++;
    end
    chk("lock_search_in_budget", 32'(m_locked && q4.size() > 0), 32'd1);
    step(4'b1111, 4'b0000, 1'b1, 1'b1);
    repeat (4) step(4'b1111, 4'b1111, 1'b1, 1'b0);

    c1_v = 1'b0;
    repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
